// File: rtl/bcd_conv_arbiter_if.sv
// Bus bundle for bcd_conv_arbiter: requester side (req/bin_in/ack),
// result side (dec_*) and converter-core side (conv_*).
// slave  : the arbiter's view.
// master : the environment's view (requesters, core, display path).
interface bcd_conv_arbiter_if #(
    parameter int NCH    = 4,
    parameter int BWIDTH = 14,
    parameter int DWIDTH = 16
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]        req;
    logic [NCH*BWIDTH-1:0] bin_in;
    logic [NCH-1:0]        ack;
    logic [DWIDTH-1:0]     dec_out;
    logic                  dec_valid;
    logic [CW-1:0]         dec_ch;
    logic                  dec_err;
    logic                  conv_start;
    logic [BWIDTH-1:0]     conv_bin;
    logic                  conv_done;
    logic [DWIDTH-1:0]     conv_dec;

    modport slave (
        input  req, bin_in, conv_done, conv_dec,
        output ack, dec_out, dec_valid, dec_ch, dec_err, conv_start, conv_bin
    );

    modport master (
        output req, bin_in, conv_done, conv_dec,
        input  ack, dec_out, dec_valid, dec_ch, dec_err, conv_start, conv_bin
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one sequential BCD converter core
// among NCH requesters. Grants a channel, latches its operand, starts the core,
// waits for completion (with timeout) and returns the tagged packed-BCD result.
// Optional feature macro: BCD_OVF_CHK_EN -- operands that do not fit in
// DWIDTH/4 decimal digits bypass the core and return all-9s with dec_err=1.
module bcd_conv_arbiter #(
    parameter int NCH     = 4,
    parameter int BWIDTH  = 14,
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    bcd_conv_arbiter_if.slave bus
);
    localparam int CW = $clog2(NCH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     gnt_idx;
    logic [CW-1:0]     scan_idx;
    logic              gnt_vld;
    logic [BWIDTH-1:0] gnt_bin;
    logic [BWIDTH-1:0] opnd [NCH];
    logic [TW-1:0]     wcnt;
    logic              wait_to;
    logic              ovf;
    logic              ovf_q;

    // Unpack the flat operand bus into one word per channel
    for (genvar g = 0; g < NCH; g++) begin : g_opnd
        assign opnd[g] = bus.bin_in[g*BWIDTH +: BWIDTH];
    end

    // Round-robin pick: scan from the farthest offset down so the first set
    // bit at or after ptr is the one left standing.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = ptr;
        scan_idx = ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            scan_idx = CW'((int'(ptr) + i) % NCH);
            if (bus.req[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign gnt_bin = opnd[gnt_idx];
    assign wait_to = (wcnt == TW'(TIMEOUT - 1));

`ifdef BCD_OVF_CHK_EN
    localparam logic [63:0]       OVF_LIM = 64'(10 ** (DWIDTH / 4));
    localparam logic [DWIDTH-1:0] ALL_9S  = {(DWIDTH/4){4'h9}};
    assign ovf = (64'(gnt_bin) >= OVF_LIM);
`else
    assign ovf = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: conv_done only matters in WAIT, and wins over timeout there
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (gnt_vld) state_nxt = ovf ? DONE : START;
            START: state_nxt = WAIT;
            WAIT:  if (bus.conv_done || wait_to) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, operand latch, wait counter and RR pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr            <= '0;
            wcnt           <= '0;
            ovf_q          <= 1'b0;
            bus.ack        <= '0;
            bus.dec_out    <= '0;
            bus.dec_valid  <= 1'b0;
            bus.dec_ch     <= '0;
            bus.dec_err    <= 1'b0;
            bus.conv_start <= 1'b0;
            bus.conv_bin   <= '0;
        end else begin
            bus.ack        <= '0;
            bus.conv_start <= 1'b0;
            bus.dec_valid  <= 1'b0;
            unique case (state)
                IDLE: if (gnt_vld) begin
                    bus.ack    <= NCH'(1) << gnt_idx;
                    bus.dec_ch <= gnt_idx;
                    ovf_q      <= ovf;
                    if (!ovf) bus.conv_bin <= gnt_bin;
`ifdef BCD_OVF_CHK_EN
                    if (ovf) begin
                        bus.dec_out <= ALL_9S;
                        bus.dec_err <= 1'b1;
                    end
`endif
                end
                START: begin
                    bus.conv_start <= 1'b1;
                    wcnt           <= '0;
                end
                WAIT: begin
                    if (bus.conv_done) begin
                        bus.dec_out   <= bus.conv_dec;
                        bus.dec_err   <= 1'b0;
                        bus.dec_valid <= 1'b1;
                    end else if (wait_to) begin
                        bus.dec_out   <= '0;
                        bus.dec_err   <= 1'b1;
                        bus.dec_valid <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    // Bypassed (overflow) results pulse here, one cycle after
                    // their ack, so ack and dec_valid never coincide.
                    bus.dec_valid <= ovf_q;
                    ovf_q         <= 1'b0;
                    ptr           <= (bus.dec_ch == CW'(NCH - 1)) ? '0 : bus.dec_ch + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus randomized
// rounds checked against a queue-based round-robin / decimal-digit model.
module tb_bcd_conv_arbiter;
    localparam int NCH     = 4;
    localparam int BWIDTH  = 14;
    localparam int DWIDTH  = 16;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bcd_conv_arbiter_if #(.NCH(NCH), .BWIDTH(BWIDTH), .DWIDTH(DWIDTH)) bus ();

    bcd_conv_arbiter #(.NCH(NCH), .BWIDTH(BWIDTH), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                ch;
        int                bin;
        logic [DWIDTH-1:0] dec;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    int                res_ch[$];
    int                n_chk = 0, n_err = 0;
    int                cyc = 0, mptr = 0;
    int                opnd [NCH];
    bit                core_dead = 0, core_busy = 0, spur = 0, spur_on_ack = 0;
    int                core_cnt = 0, lat = 14;
    logic [DWIDTH-1:0] core_val = '0;
    int                n_start = 0, start_cyc = 0, valid_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DWIDTH-1:0] to_bcd(input int v);
        logic [DWIDTH-1:0] r;
        r = '0;
        for (int d = 0; d < DWIDTH/4; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int rr_pick(input logic [NCH-1:0] r, input int p);
        for (int i = 0; i < NCH; i++)
            if (r[(p + i) % NCH]) return (p + i) % NCH;
        return -1;
    endfunction

    task automatic set_op(input int k, input int v);
        opnd[k] = v;
        bus.bin_in[k*BWIDTH +: BWIDTH] = BWIDTH'(v);
    endtask

    // One cycle: sample outputs at the falling edge, update model, drive core
    task automatic tick();
        exp_t e;
        int   c;
        @(negedge clk);
        cyc++;
        if (bus.dec_valid) begin
            chk("ack_excl", 64'(|bus.ack), 64'(0));
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("dec_out", 64'(bus.dec_out), 64'(e.dec));
                chk("dec_ch",  64'(bus.dec_ch),  64'(e.ch));
                chk("dec_err", 64'(bus.dec_err), 64'(e.err));
                mptr = (e.ch + 1) % NCH;
            end
            res_ch.push_back(int'(bus.dec_ch));
            valid_cyc = cyc;
        end
        if (bus.ack != '0) begin
            c = rr_pick(bus.req, mptr);
            chk("ack", 64'(bus.ack), (c < 0) ? 64'(0) : (64'(1) << c));
            if (c >= 0) begin
                e.ch  = c;
                e.bin = opnd[c];
                e.dec = core_dead ? '0 : to_bcd(opnd[c]);
                e.err = core_dead;
`ifdef BCD_OVF_CHK_EN
                if (opnd[c] >= 10 ** (DWIDTH/4)) begin
                    e.dec = {(DWIDTH/4){4'h9}};
                    e.err = 1'b1;
                end
`endif
                exp_q.push_back(e);
                bus.req[c] = 1'b0;
            end
            if (spur_on_ack) begin
                spur        = 1;
                spur_on_ack = 0;
            end
        end
        if (bus.conv_start) begin
            n_start++;
            start_cyc = cyc;
            if (exp_q.size() > 0) chk("conv_bin", 64'(bus.conv_bin), 64'(exp_q[0].bin));
            else                  chk("start_no_grant", 64'(1), 64'(0));
            core_busy = !core_dead;
            core_cnt  = lat;
            core_val  = to_bcd(int'(bus.conv_bin));
        end
        bus.conv_done = 1'b0;
        bus.conv_dec  = DWIDTH'($urandom);
        if (spur) begin
            bus.conv_done = 1'b1;
            bus.conv_dec  = 16'hDEAD;
            spur          = 0;
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                bus.conv_done = 1'b1;
                bus.conv_dec  = core_val;
                core_busy     = 0;
            end else begin
                core_cnt--;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((bus.req != '0 || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk({tag, "_drain_timeout"}, 64'(1), 64'(0));
        tick();
        tick();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ack",        64'(bus.ack),        64'(0));
        chk("rst_dec_out",    64'(bus.dec_out),    64'(0));
        chk("rst_dec_valid",  64'(bus.dec_valid),  64'(0));
        chk("rst_dec_ch",     64'(bus.dec_ch),     64'(0));
        chk("rst_dec_err",    64'(bus.dec_err),    64'(0));
        chk("rst_conv_start", 64'(bus.conv_start), 64'(0));
        chk("rst_conv_bin",   64'(bus.conv_bin),   64'(0));
        exp_q.delete();
        mptr          = 0;
        core_busy     = 0;
        spur          = 0;
        bus.req       = '0;
        bus.conv_done = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int s0, n;
        bus.req       = '0;
        bus.bin_in    = '0;
        bus.conv_done = 1'b0;
        bus.conv_dec  = '0;
        for (int k = 0; k < NCH; k++) set_op(k, 0);
        do_reset();

        // Single request, 14-cycle core
        set_op(1, 243);
        lat = 14;
        bus.req = 4'b0010;
        drain("t1");
        chk("t1_starts", 64'(n_start), 64'(1));
        chk("t1_dec",    64'(bus.dec_out), 64'h0243);
        chk("t1_ch",     64'(bus.dec_ch),  64'(1));

        // All four held from pointer 0, then 1001
        do_reset();
        res_ch.delete();
        set_op(0, 11); set_op(1, 243); set_op(2, 9999); set_op(3, 0);
        lat = 3;
        bus.req = 4'b1111;
        drain("t2");
        chk("t2_count", 64'(res_ch.size()), 64'(4));
        for (int i = 0; i < 4 && i < res_ch.size(); i++)
            chk($sformatf("t2_order%0d", i), 64'(res_ch[i]), 64'(i));
        chk("t2_last_dec", 64'(bus.dec_out), 64'h0000);
        res_ch.delete();
        bus.req = 4'b1001;
        drain("t2b");
        chk("t2b_count", 64'(res_ch.size()), 64'(2));
        if (res_ch.size() == 2) begin
            chk("t2b_first",  64'(res_ch[0]), 64'(0));
            chk("t2b_second", 64'(res_ch[1]), 64'(3));
        end

        // Dead core: timeout exactly TIMEOUT cycles after entering WAIT
        core_dead = 1;
        set_op(2, 777);
        bus.req = 4'b0100;
        drain("t3");
        chk("t3_latency", 64'(valid_cyc - start_cyc), 64'(TIMEOUT));
        chk("t3_err",     64'(bus.dec_err), 64'(1));
        chk("t3_out",     64'(bus.dec_out), 64'(0));
        core_dead = 0;
        set_op(0, 5);
        bus.req = 4'b0001;
        drain("t3b");
        chk("t3b_dec", 64'(bus.dec_out), 64'h0005);
        chk("t3b_err", 64'(bus.dec_err), 64'(0));

        // Reset during WAIT: abandon, then pointer back at 0
        lat = 20;
        set_op(1, 42);
        s0 = n_start;
        n  = 0;
        bus.req = 4'b0010;
        while (n_start == s0 && n < 200) begin tick(); n++; end
        if (n >= 200) chk("t4_start_timeout", 64'(1), 64'(0));
        tick(); tick(); tick();
        do_reset();
        tick(); tick();
        res_ch.delete();
        set_op(0, 321); set_op(2, 654);
        lat = 5;
        bus.req = 4'b0101;
        drain("t4");
        chk("t4_count", 64'(res_ch.size()), 64'(2));
        if (res_ch.size() > 0) chk("t4_first", 64'(res_ch[0]), 64'(0));

        // Spurious conv_done in IDLE and in START
        spur = 1;
        tick(); tick();
        spur_on_ack = 1;
        set_op(2, 1234);
        bus.req = 4'b0100;
        drain("t5");
        chk("t5_dec", 64'(bus.dec_out), 64'h1234);
        chk("t5_err", 64'(bus.dec_err), 64'(0));

        // Out-of-range operand
        s0 = n_start;
        set_op(2, 12000);
        bus.req = 4'b0100;
        drain("t6");
`ifdef BCD_OVF_CHK_EN
        chk("t6_no_start", 64'(n_start), 64'(s0));
        chk("t6_dec",      64'(bus.dec_out), 64'h9999);
        chk("t6_err",      64'(bus.dec_err), 64'(1));
`else
        chk("t6_start", 64'(n_start), 64'(s0 + 1));
        chk("t6_dec",   64'(bus.dec_out), 64'h2000);
        chk("t6_err",   64'(bus.dec_err), 64'(0));
`endif

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            lat = $urandom_range(1, 24);
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 7) == 0) set_op(k, $urandom_range(10000, 16383));
                else                           set_op(k, $urandom_range(0, 9999));
            end
            core_dead = ($urandom_range(0, 9) == 0);
            bus.req = NCH'($urandom_range(1, 15));
            drain("rnd");
            core_dead = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
